// File: rtl/flash_mem_responder.sv
// Avalon-MM read-only stand-in for the flash core: returns a 16-bit ramp pattern with fixed latency.
// Optional macro FLASH_RSP_STALL_EN adds pseudo-random waitrequest stalls from a 16-bit LFSR.
module flash_mem_responder #(
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned MAX_PENDING    = 2,
    parameter int unsigned STARTUP_CYCLES = 4,
    parameter int unsigned WRAP_WORDS     = 1048576,
    parameter logic [15:0] SEED           = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flash_mem_read,
    input  logic        flash_mem_write,
    input  logic [22:0] flash_mem_address,
    input  logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_burstcount,
    output logic        flash_mem_waitrequest,
    output logic [31:0] flash_mem_readdata,
    output logic        flash_mem_readdatavalid,
    output logic [7:0]  oob_count,
    output logic        write_seen
);

    typedef enum logic {ST_STARTUP, ST_READY} state_t;

    state_t      r_state;
    logic [7:0]  r_startup_cnt;
    logic [3:0]  r_pending;
    logic        r_waitreq;
    logic        r_rdv;
    logic [31:0] r_rdata;
    logic [7:0]  r_oob;
    logic        r_ws;

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [31:0]             r_pipe_data [READ_LATENCY];

    logic        w_accept;
    logic        w_oob;
    logic [31:0] w_word;
    logic [31:0] w_data;
    logic [3:0]  w_pending_next;
    logic        w_stall_next;
    logic        w_unused;

    // Burst length is ignored: every read is a single word.
    assign w_unused = flash_mem_burstcount;

    assign w_accept       = flash_mem_read & ~r_waitreq;
    assign w_oob          = ({9'd0, flash_mem_address} >= WRAP_WORDS);
    assign w_word         = {({flash_mem_address[14:0], 1'b1} ^ SEED),
                             ({flash_mem_address[14:0], 1'b0} ^ SEED)};
    assign w_pending_next = r_pending + {3'd0, w_accept} - {3'd0, r_rdv};

    always_comb begin
        w_data = 32'd0;
        if (!w_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (flash_mem_byteenable[i]) begin
                    w_data[8*i +: 8] = w_word[8*i +: 8];
                end
            end
        end
    end

`ifdef FLASH_RSP_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    // x^16+x^14+x^13+x^11+1, only stepping once the startup window is over.
    assign w_lfsr_next  = (r_state == ST_READY) ?
                          {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]} :
                          r_lfsr;
    assign w_stall_next = (w_lfsr_next[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_stall_next = 1'b0;
`endif

    // waitrequest is registered from the next pending count, so it never looks at read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_STARTUP;
            r_startup_cnt <= 8'd0;
            r_pending     <= 4'd0;
            r_waitreq     <= 1'b1;
            r_rdv         <= 1'b0;
            r_rdata       <= 32'd0;
            r_oob         <= 8'd0;
            r_ws          <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_rdv     <= r_pipe_vld[READ_LATENCY-1];
            if (r_pipe_vld[READ_LATENCY-1]) begin
                r_rdata <= r_pipe_data[READ_LATENCY-1];
            end
            if (w_accept && w_oob && (r_oob != 8'hFF)) begin
                r_oob <= r_oob + 8'd1;
            end
            if (flash_mem_write) begin
                r_ws <= 1'b1;
            end
            case (r_state)
                ST_STARTUP: begin
                    if (r_startup_cnt == 8'(STARTUP_CYCLES - 1)) begin
                        r_state   <= ST_READY;
                        r_waitreq <= w_stall_next;
                    end else begin
                        r_startup_cnt <= r_startup_cnt + 8'd1;
                        r_waitreq     <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_waitreq <= (w_pending_next == 4'(MAX_PENDING)) | w_stall_next;
                end
                default: begin
                    r_state   <= ST_STARTUP;
                    r_waitreq <= 1'b1;
                end
            endcase
        end
    end

    // Stage 0 loads on the accepting edge; the output register fires READ_LATENCY edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data[i] <= 32'd0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept;
            if (w_accept) begin
                r_pipe_data[0] <= w_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign flash_mem_waitrequest   = r_waitreq;
    assign flash_mem_readdata      = r_rdata;
    assign flash_mem_readdatavalid = r_rdv;
    assign oob_count               = r_oob;
    assign write_seen              = r_ws;

endmodule

// File: tb/tb_flash_mem_responder.sv
// Bench for flash_mem_responder: vector table, directed multi-cycle sequences and random traffic
// against a cycle-indexed model of accepted reads.
module tb_flash_mem_responder;

    localparam int          L     = 3;
    localparam int          MAXP  = 2;
    localparam int          SU    = 4;
    localparam int unsigned WRAP  = 1048576;
    localparam logic [15:0] SEEDV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flash_mem_read = 1'b0;
    logic        flash_mem_write = 1'b0;
    logic [22:0] flash_mem_address = 23'd0;
    logic [3:0]  flash_mem_byteenable = 4'hF;
    logic        flash_mem_burstcount = 1'b1;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [7:0]  oob_count;
    logic        write_seen;

    flash_mem_responder #(
        .READ_LATENCY(L), .MAX_PENDING(MAXP), .STARTUP_CYCLES(SU),
        .WRAP_WORDS(WRAP), .SEED(SEEDV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .flash_mem_read(flash_mem_read), .flash_mem_write(flash_mem_write),
        .flash_mem_address(flash_mem_address), .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_burstcount(flash_mem_burstcount), .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata), .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .oob_count(oob_count), .write_seen(write_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: n = edges since reset release; acc_e holds accept edges still occupying a slot.
    int          n;
    int          acc_e[$];
    logic [31:0] acc_d[$];
    logic [31:0] last_d;
    int          oob_m;
    bit          ws_m;
    bit          last_acc;
    int          dut_out;
    bit          dut_vld_now;
    int          first_vld_n;
    logic [31:0] first_vld_d;
    int          vn[$];
    logic [31:0] vd[$];

    typedef struct {
        logic [22:0] addr;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t cycle=%0d: got %h expected %h", nm, $time, n, act, exp);
        end
    endtask

    function automatic logic [31:0] model_data(input int unsigned a, input logic [3:0] be);
        int unsigned lo;
        int unsigned hi;
        logic [31:0] w;
        if (a >= WRAP) return 32'd0;
        lo = ((2 * a) % 65536) ^ SEEDV;
        hi = ((2 * a + 1) % 65536) ^ SEEDV;
        w = {hi[15:0], lo[15:0]};
        for (int i = 0; i < 4; i++) begin
            if (!be[i]) w[8*i +: 8] = 8'h00;
        end
        return w;
    endfunction

    function automatic logic [31:0] log_d(input int i);
        return (i < vd.size()) ? vd[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int log_n(input int i);
        return (i < vn.size()) ? vn[i] : -1;
    endfunction

    task automatic tick(input bit rd, input bit wr, input logic [22:0] a, input logic [3:0] be);
        bit exp_w;
        bit exp_v;
        flash_mem_read       = rd;
        flash_mem_write      = wr;
        flash_mem_address    = a;
        flash_mem_byteenable = be;
        flash_mem_burstcount = 1'($urandom_range(0, 1));
        exp_w    = (n < SU) || (acc_e.size() == MAXP);
        last_acc = rd && !exp_w;
        if (rd && !flash_mem_waitrequest) dut_out++;
        @(posedge clk);
        #1;
        n++;
        if (last_acc) begin
            acc_e.push_back(n);
            acc_d.push_back(model_data(a, be));
            if ((a >= WRAP) && (oob_m < 255)) oob_m++;
        end
        if (wr) ws_m = 1'b1;
        while ((acc_e.size() > 0) && (acc_e[0] < n - L)) begin
            void'(acc_e.pop_front());
            void'(acc_d.pop_front());
        end
        exp_v = (acc_e.size() > 0) && (acc_e[0] == n - L);
        if (exp_v) last_d = acc_d[0];
        exp_w = (n < SU) || (acc_e.size() == MAXP);
        dut_vld_now = flash_mem_readdatavalid;
        if (dut_vld_now) begin
            dut_out--;
            vn.push_back(n);
            vd.push_back(flash_mem_readdata);
            if (first_vld_n < 0) begin
                first_vld_n = n;
                first_vld_d = flash_mem_readdata;
            end
        end
        chk("readdatavalid", 32'(flash_mem_readdatavalid), 32'(exp_v));
        chk("readdata", flash_mem_readdata, last_d);
        chk("waitrequest", 32'(flash_mem_waitrequest), 32'(exp_w));
        chk("oob_count", 32'(oob_count), 32'(oob_m));
        chk("write_seen", 32'(write_seen), 32'(ws_m));
        chk("outstanding_le_max", 32'(dut_out <= MAXP), 32'd1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 23'd0, 4'hF);
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        flash_mem_read  = 1'b0;
        flash_mem_write = 1'b0;
        #1;
        chk("rst_waitrequest", 32'(flash_mem_waitrequest), 32'd1);
        chk("rst_readdatavalid", 32'(flash_mem_readdatavalid), 32'd0);
        chk("rst_readdata", flash_mem_readdata, 32'd0);
        chk("rst_oob_count", 32'(oob_count), 32'd0);
        chk("rst_write_seen", 32'(write_seen), 32'd0);
        acc_e.delete();
        acc_d.delete();
        vn.delete();
        vd.delete();
        last_d = 32'd0; oob_m = 0; ws_m = 1'b0; dut_out = 0; first_vld_n = -1; n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("release_waitrequest", 32'(flash_mem_waitrequest), 32'd1);
    endtask

    task automatic single_read(input logic [22:0] a, input logic [3:0] be, output logic [31:0] d);
        int k;
        bit ok;
        k = 0;
        tick(1'b1, 1'b0, a, be);
        while (!last_acc && (k < 20)) begin
            tick(1'b1, 1'b0, a, be);
            k++;
        end
        k = 0;
        ok = 1'b0;
        while (!ok && (k < 20)) begin
            tick(1'b0, 1'b0, a, be);
            ok = dut_vld_now;
            k++;
        end
        d = flash_mem_readdata;
        chk("single_read_response_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [22:0] a;
        int sel;

        vecs[0]  = '{23'd0,       4'hF,    32'h0001_0000};
        vecs[1]  = '{23'd5,       4'hF,    32'h000B_000A};
        vecs[2]  = '{23'd6,       4'hF,    32'h000D_000C};
        vecs[3]  = '{23'd1048575, 4'hF,    32'hFFFF_FFFE};
        vecs[4]  = '{23'd1048576, 4'hF,    32'h0000_0000};
        vecs[5]  = '{23'd2,       4'b0011, 32'h0000_0004};
        vecs[6]  = '{23'h007FFF,  4'hF,    32'hFFFF_FFFE};
        vecs[7]  = '{23'h008000,  4'hF,    32'h0001_0000};
        vecs[8]  = '{23'h001234,  4'b1100, 32'h2469_0000};
        vecs[9]  = '{23'h000ABC,  4'b0101, 32'h0079_0078};
        vecs[10] = '{23'h7FFFFF,  4'hF,    32'h0000_0000};
        vecs[11] = '{23'h004321,  4'b1010, 32'h8600_8600};

        #1;
        apply_reset();

        // Read held high from reset release: accepted on edge 5, answered at edge 8.
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 23'd0, 4'hF);
        chk("first_valid_cycle", 32'(first_vld_n), 32'd8);
        chk("first_valid_data", first_vld_d, 32'h0001_0000);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 23'(i), 4'hF);
        idle(6);

        // Back-to-back accepts give back-to-back valids.
        vn.delete(); vd.delete();
        tick(1'b1, 1'b0, 23'd5, 4'hF);
        tick(1'b1, 1'b0, 23'd6, 4'hF);
        idle(6);
        chk("b2b_count", 32'(vn.size()), 32'd2);
        chk("b2b_gap", 32'(log_n(1) - log_n(0)), 32'd1);
        chk("b2b_data0", log_d(0), 32'h000B_000A);
        chk("b2b_data1", log_d(1), 32'h000D_000C);

        // Range boundary.
        vn.delete(); vd.delete();
        tick(1'b1, 1'b0, 23'd1048576, 4'hF);
        tick(1'b1, 1'b0, 23'd1048575, 4'hF);
        idle(6);
        chk("oob_data", log_d(0), 32'h0000_0000);
        chk("edge_data", log_d(1), 32'hFFFF_FFFE);
        chk("oob_count_one", 32'(oob_count), 32'd1);

        // Byte lanes, then a lone write.
        single_read(23'd2, 4'b0011, d);
        chk("be_0011_data", d, 32'h0000_0004);
        vn.delete(); vd.delete();
        tick(1'b0, 1'b1, 23'd9, 4'hF);
        idle(5);
        chk("write_seen_set", 32'(write_seen), 32'd1);
        chk("write_no_valid", 32'(vn.size()), 32'd0);

        for (int i = 0; i < 12; i++) begin
            single_read(vecs[i].addr, vecs[i].be, d);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
        end

        // Random traffic, including simultaneous read+write.
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 23'($urandom_range(0, 255));
                1:       a = 23'($urandom_range(1048570, 1048581));
                2:       a = 23'($urandom);
                default: a = 23'($urandom_range(0, 1048575));
            endcase
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, a, 4'($urandom));
        end
        idle(6);

        // Saturation of the out-of-range counter.
        for (int i = 0; i < 650; i++) tick(1'b1, 1'b0, 23'h7FFFFF, 4'hF);
        idle(6);
        chk("oob_count_saturated", 32'(oob_count), 32'd255);

        // Reset with reads in flight: no stale valid afterwards, startup repeats.
        tick(1'b1, 1'b0, 23'd7, 4'hF);
        tick(1'b1, 1'b0, 23'd8, 4'hF);
        idle(1);
        apply_reset();
        idle(12);
        chk("no_valid_after_reset", 32'(vn.size()), 32'd0);
        single_read(23'd6, 4'hF, d);
        chk("post_reset_data", d, 32'h000D_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_mem_responder.md
Name: flash_mem_responder

Overview:
- Avalon-MM read-slave stand-in for the on-board flash core: the responder end of the flash_mem_* interface that the sample player drives as master.
- Returns a deterministic 16-bit-per-sample ramp pattern with fixed read latency, bounded outstanding reads, and waitrequest back-pressure.
- Used in simulation and in FPGA bring-up in place of the flash instance, so the player datapath can be checked against known sample values.

Parameters:
- READ_LATENCY, 3, cycles from read acceptance to flash_mem_readdatavalid (legal 1..8).
- MAX_PENDING, 2, maximum accepted-but-unanswered reads (legal 1..READ_LATENCY).
- STARTUP_CYCLES, 4, cycles waitrequest stays high after reset release (legal 1..255).
- WRAP_WORDS, 1048576, number of valid word addresses; addresses at or above this are out of range.
- SEED, 16'h0000, XOR mask applied to every generated sample.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  asynchronous active-low reset.
- flash_mem_read  in  1  read request.
- flash_mem_write  in  1  write request; unsupported.
- flash_mem_address  in  23  word address.
- flash_mem_byteenable  in  4  byte-lane enables.
- flash_mem_burstcount  in  1  burst count; only 1 is supported.
- flash_mem_waitrequest  out  1  back-pressure; a request is accepted only while this is low.
- flash_mem_readdata  out  32  response data.
- flash_mem_readdatavalid  out  1  single-cycle strobe; flash_mem_readdata is valid while it is high.
- oob_count  out  8  saturating count of out-of-range reads.
- write_seen  out  1  sticky flag: a write was attempted.

Behaviour:
- Reset (asynchronous, rst_n low):
  - waitrequest=1, readdatavalid=0, readdata=0, oob_count=0, write_seen=0.
  - Pending count, latency pipeline and startup counter are cleared.
  - Reads in flight when reset asserts are discarded; no late valid appears after reset release.
- State machine:
  - STARTUP: waitrequest=1 for exactly STARTUP_CYCLES cycles after rst_n rises, then go to READY.
  - READY: waitrequest = (pending == MAX_PENDING).
  - waitrequest is a function of registered state only; it never depends combinationally on read or write.
- Acceptance:
  - A read is accepted on a rising edge where read=1 and waitrequest=0.
  - The accepted address and byteenable are captured at that edge.
  - At most one acceptance per cycle.
- Latency:
  - readdatavalid is high for one cycle, exactly READ_LATENCY cycles after the accepting edge.
  - Responses return in order.
  - Back-to-back accepts give back-to-back valids.
- Pending count:
  - +1 on accept, −1 on valid; both in the same cycle leaves it unchanged.
  - Acceptance in the cycle a valid frees a slot follows from the registered count: the slot frees on the following cycle.
- Data for word address A (A < WRAP_WORDS):
  - readdata[15:0] = (2A)[15:0] ^ SEED.
  - readdata[31:16] = (2A+1)[15:0] ^ SEED.
  - Arithmetic is modulo 2^16.
- Byteenable: each disabled byte lane returns 8'h00 in its response.
- Out of range (A >= WRAP_WORDS):
  - Read is still accepted and answered with readdata=0 at the normal latency.
  - oob_count increments, saturating at 255.
- Readdata hold: readdata holds its last value when valid is low; it is 0 before the first response.
- Writes:
  - write=1 alone: no waitrequest change, no response, data dropped, write_seen<=1.
  - read and write high together: the read is handled normally; write_seen<=1.
- Burstcount: value ignored; every read is treated as single-word.

Optional Feature:
FLASH_RSP_STALL_EN:
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every cycle in READY.
  - waitrequest is additionally forced high when lfsr[1:0]==2'b00, which exercises master stall handling.
  - Latency, ordering and data rules are unchanged.
- Undefined: no LFSR logic; waitrequest follows only the startup and pending rules.

Test Plan:
- Release reset, hold read=1 at address 0 → waitrequest high for 4 cycles, accepted on the 5th; valid 3 cycles later with readdata=32'h0001_0000.
- Read address 5, then address 6 on consecutive accepts → valids on consecutive cycles with 32'h000B_000A then 32'h000D_000C.
- Hold read=1 continuously with default parameters → waitrequest toggles so that no more than 2 reads are ever outstanding; every response arrives in order at exactly 3 cycles.
- Read address 1048576, then 1048575 → first returns 0 and oob_count=1; second returns 32'hFFFF_FFFE.
- Read address 2 with byteenable=4'b0011, then write=1 alone → readdata=32'h0000_0004, write_seen=1, no extra valid.
- Accept 2 reads, assert rst_n low one cycle later → outputs reset immediately; after release no valid appears and the startup sequence repeats.
